// File: rtl/wb_pkg.sv
// Wishbone bus constants shared by the arbiter, the address decoder and future bus blocks.
package wb_pkg;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... modulo N.
module rr_pick
  import wb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] cand;
    pick = '0;
    idx  = '0;
    any  = |req;
    cand = '0;
    // Scan from the farthest candidate down so the nearest one after last wins.
    for (int o = N; o >= 1; o--) begin
      cand = IW'((int'(last) + o) % N);
      if (req[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

endmodule

// File: rtl/wb_arb.sv
// Round-robin Wishbone arbiter: NM initiators share one downstream bus, with an ack watchdog.
module wb_arb
  import wb_pkg::*;
#(
  parameter  int NM      = 2,
  parameter  int AW      = WB_AW,
  parameter  int DW      = WB_DW,
  parameter  int TIMEOUT = 255,
  localparam int SW      = DW / 8,
  localparam int IW      = (NM > 1) ? clog2(NM) : 1,
  localparam int WW      = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*SW-1:0] m_sel_i,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [DW-1:0]    m_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [SW-1:0]    s_sel_o,
  output logic [DW-1:0]    s_dat_o,
  input  logic             s_ack_i,
  input  logic [DW-1:0]    s_dat_i
);

  // Handshake: a beat is offered while cyc & stb are high and completes in the cycle ack (or
  // err) is high; cyc held across beats keeps ownership, and a slave never acks once stb falls.

  arb_state_t    state, state_n;
  logic [NM-1:0] gnt, gnt_n;
  logic [IW-1:0] last, last_n;
  logic [WW-1:0] wdt, wdt_n;
  logic [NM-1:0] pick;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          busy;
  logic          stb_g;
  logic          err_now;

  rr_pick #(.N(NM)) u_pick (
    .req  (m_cyc_i),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      last  <= IW'(NM - 1);
      wdt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
      wdt   <= wdt_n;
    end
  end

  assign busy = (state == ARB_GRANTED);

  // Muxes are AND-OR over gnt so the downstream goes quiet as soon as reset clears the grant.
  always_comb begin
    s_cyc_o = 1'b0;
    stb_g   = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < NM; k++) begin
      if (gnt[k]) begin
        s_cyc_o = m_cyc_i[k];
        stb_g   = m_stb_i[k];
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[k*AW +: AW];
        s_sel_o = m_sel_i[k*SW +: SW];
        s_dat_o = m_dat_i[k*DW +: DW];
      end
    end
  end

  // An ack in the limit cycle wins over the watchdog.
  assign err_now = (TIMEOUT > 0) && (wdt == WW'(TIMEOUT)) && !s_ack_i;
  assign s_stb_o = stb_g & ~err_now;
  assign m_ack_o = {NM{s_ack_i}} & gnt & m_stb_i;
  assign m_err_o = {NM{err_now}} & gnt;
  assign m_dat_o = s_dat_i;

  always_comb begin
    wdt_n = wdt + WW'(1);
    if (TIMEOUT == 0 || !busy || !stb_g || s_ack_i || err_now) wdt_n = '0;
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_n = ARB_GRANTED;
          gnt_n   = pick;
          last_n  = pick_idx;
        end
      end
      ARB_GRANTED: begin
        if (!m_cyc_i[last]) begin
          state_n = ARB_IDLE;
          gnt_n   = '0;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: two initiators, watchdog limit of 8 cycles.
module tb_wb_arb;

  localparam int NM = 2;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  localparam logic [AW-1:0] A0 = 30'h1000_0004;
  localparam logic [AW-1:0] A1 = 30'h0000_0200;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*SW-1:0] m_sel;
  logic [NM*DW-1:0] m_dat;
  logic [NM-1:0]    m_ack, m_err;
  logic [DW-1:0]    m_dat_r;
  logic             s_cyc, s_stb, s_we;
  logic [AW-1:0]    s_adr;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dat_w;
  logic             s_ack;
  logic [DW-1:0]    s_dat_r;

  int errors = 0;
  int checks = 0;

  wb_arb #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_sel_i (m_sel),
    .m_dat_i (m_dat),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .m_dat_o (m_dat_r),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_we_o  (s_we),
    .s_adr_o (s_adr),
    .s_sel_o (s_sel),
    .s_dat_o (s_dat_w),
    .s_ack_i (s_ack),
    .s_dat_i (s_dat_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    s_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_adr   = {A1, A0};
    m_sel   = {4'h3, 4'hC};
    m_dat   = {32'h1234_5678, 32'hDEAD_BEEF};
    s_ack   = 1'b1;
    s_dat_r = 32'hA5A5_5A5A;
    tick();
    tick();
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", s_cyc); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", s_stb); end
    checks++; if (s_adr !== '0) begin errors++; $display("FAIL reset_adr: got %h want 0", s_adr); end
    checks++; if (s_dat_w !== '0) begin errors++; $display("FAIL reset_dat: got %h want 0", s_dat_w); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", m_ack); end
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", m_err); end
    checks++; if (m_dat_r !== 32'hA5A5_5A5A) begin errors++; $display("FAIL reset_rdata: got %h want a5a55a5a", m_dat_r); end
    s_ack = 1'b0;
    rst   = 1'b0;
    tick();
  endtask

  task automatic test_single();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    m_we  = 2'b01;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_arb_latency: got %b want 0", s_cyc); end
    tick();
    checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL single_cyc: got %b want 1", s_cyc); end
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL single_stb: got %b want 1", s_stb); end
    checks++; if (s_adr !== A0) begin errors++; $display("FAIL single_adr: got %h want %h", s_adr, A0); end
    checks++; if (s_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", s_we); end
    checks++; if (s_sel !== 4'hC) begin errors++; $display("FAIL single_sel: got %h want c", s_sel); end
    checks++; if (s_dat_w !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdat: got %h want deadbeef", s_dat_w); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL single_noack1: got %b want 00", m_ack); end
    tick();
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL single_noack2: got %b want 00", m_ack); end
    tick();
    s_ack   = 1'b1;
    s_dat_r = 32'h0BAD_F00D;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL single_ack: got %b want 01", m_ack); end
    checks++; if (m_dat_r !== 32'h0BAD_F00D) begin errors++; $display("FAIL single_rdata: got %h want 0badf00d", m_dat_r); end
    tick();
    s_ack = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", s_cyc); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL single_ack_once: got %b want 00", m_ack); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_adr;
    logic [NM-1:0] exp_ack;
    do_reset();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_adr = (i % 2 == 0) ? A0 : A1;
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checks++; if (s_adr !== exp_adr) begin errors++; $display("FAIL rr_grant%0d: adr got %h want %h", i, s_adr, exp_adr); end
      s_ack = 1'b1;
      #1;
      checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", i, m_ack, exp_ack); end
      tick();
      s_ack = 1'b0;
      m_cyc = ~exp_ack;
      m_stb = ~exp_ack;
      #1;
      checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_drop%0d: got %b want 0", i, s_cyc); end
      tick();
      m_cyc = 2'b11;
      m_stb = 2'b11;
      #1;
      checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got %b want 0", i, s_cyc); end
    end
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();
  endtask

  task automatic test_bus_lock();
    do_reset();
    m_cyc = 2'b10;
    m_stb = 2'b10;
    tick();
    m_cyc = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_stb = 2'b11;
      s_ack = 1'b1;
      #1;
      checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL lock_ack%0d: got %b want 10", b, m_ack); end
      checks++; if (s_adr !== A1) begin errors++; $display("FAIL lock_adr%0d: got %h want %h", b, s_adr, A1); end
      tick();
      m_stb = 2'b01;
      s_ack = 1'b0;
      #1;
      checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL lock_hold%0d: got %b want 1", b, s_cyc); end
      tick();
    end
    m_cyc = 2'b01;
    m_stb = 2'b01;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL lock_release: got %b want 0", s_cyc); end
    tick();
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL lock_idle: got %b want 0", s_cyc); end
    tick();
    checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL lock_next_cyc: got %b want 1", s_cyc); end
    checks++; if (s_adr !== A0) begin errors++; $display("FAIL lock_next_adr: got %h want %h", s_adr, A0); end
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    logic [NM-1:0] exp_err;
    logic          exp_stb;
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    for (int n = 1; n <= 18; n++) begin
      exp_err = (n == 9 || n == 18) ? 2'b01 : 2'b00;
      exp_stb = (n == 9 || n == 18) ? 1'b0 : 1'b1;
      checks++; if (m_err !== exp_err) begin errors++; $display("FAIL wdt_err_c%0d: got %b want %b", n, m_err, exp_err); end
      checks++; if (s_stb !== exp_stb) begin errors++; $display("FAIL wdt_stb_c%0d: got %b want %b", n, s_stb, exp_stb); end
      tick();
    end
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    for (int n = 1; n <= 8; n++) begin
      checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL limit_pre_err_c%0d: got %b want 00", n, m_err); end
      tick();
    end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL limit_ack: got %b want 01", m_ack); end
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL limit_err: got %b want 00", m_err); end
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL limit_stb: got %b want 1", s_stb); end
    tick();
    s_ack = 1'b0;
    #1;
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL limit_after_err: got %b want 00", m_err); end
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_cycle();
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL rstmid_pre_ack: got %b want 01", m_ack); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: got %b want 0", s_cyc); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rstmid_stb: got %b want 0", s_stb); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rstmid_ack: got %b want 00", m_ack); end
    #1;
    rst   = 1'b0;
    s_ack = 1'b0;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b want 0", s_cyc); end
    tick();
    checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_regrant_cyc: got %b want 1", s_cyc); end
    checks++; if (s_adr !== A0) begin errors++; $display("FAIL rstmid_regrant_adr: got %h want %h", s_adr, A0); end
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bus_lock();
    test_watchdog();
    test_ack_at_limit();
    test_reset_mid_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
Name: wb_arb

Overview:
- Round-robin Wishbone arbiter: the fan-in counterpart to the bus address decoder. NM initiators (CPU, DMA, debug) share one downstream bus.
- The granted initiator's cycle is forwarded to the downstream bus, which feeds the address decoder.
- A bus watchdog returns an error to the initiator when no acknowledge arrives within TIMEOUT cycles, so an unmapped or hung slave cannot stall the system.

Parameters:
- NM, 2, number of initiators (2..8).
- AW, 30, word address width.
- DW, 32, data width; SW = DW/8 byte selects.
- TIMEOUT, 255, cycles without ack before error; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- m_cyc_i  in  NM  per-initiator cycle (bus ownership request).
- m_stb_i  in  NM  per-initiator strobe.
- m_we_i  in  NM  per-initiator write enable.
- m_adr_i  in  NM*AW  packed addresses; initiator k at [k*AW +: AW].
- m_sel_i  in  NM*SW  packed byte selects.
- m_dat_i  in  NM*DW  packed write data.
- m_ack_o  out  NM  per-initiator ack.
- m_err_o  out  NM  per-initiator error (watchdog).
- m_dat_o  out  DW  read data, broadcast to all initiators.
- s_cyc_o, s_stb_o, s_we_o  out  1  downstream controls.
- s_adr_o  out  AW  downstream address.
- s_sel_o  out  SW  downstream byte selects.
- s_dat_o  out  DW  downstream write data.
- s_ack_i  in  1  downstream ack.
- s_dat_i  in  DW  downstream read data.

Behaviour:
- State: `busy` (1 bit), `gnt` (one-hot NM), `last` (index of the most recent grant), `wdt` (watchdog counter, clog2(TIMEOUT+1) bits).
- Reset (asynchronous): busy=0, gnt=0, last=NM-1, wdt=0. All s_* outputs and m_ack_o/m_err_o are 0; m_dat_o follows s_dat_i.
- IDLE (busy=0):
  - Requests are m_cyc_i bits.
  - If any request is set, pick the first requester scanning last+1, last+2, ... modulo NM.
  - Next cycle: gnt=one-hot(pick), last=pick, busy=1.
  - Arbitration latency is 1 cycle; s_cyc_o is 0 in IDLE.
- GRANTED (busy=1):
  - s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g] & ~err_now. We/adr/sel/dat are muxed from initiator g.
  - All mux outputs are combinational from `gnt`.
- Ack routing:
  - m_ack_o[k] = s_ack_i & gnt[k] & m_stb_i[k].
  - Non-granted initiators never see ack or err.
- Release:
  - When m_cyc_i[g]=0 while busy, go to IDLE next cycle (gnt=0).
  - There is always one idle cycle between grants, so no initiator can be granted in the same cycle another is released.
  - An initiator holding cyc across multiple stb beats keeps the bus (bus lock).
- Watchdog (TIMEOUT>0):
  - wdt clears when busy=0, m_stb_i[g]=0, or s_ack_i=1.
  - Otherwise wdt increments.
  - err_now = (wdt==TIMEOUT) & ~s_ack_i.
  - On err_now: m_err_o[g]=1 for exactly that cycle, s_stb_o is forced 0 that cycle, and wdt clears.
  - An ack arriving in the same cycle as wdt==TIMEOUT wins: ack is delivered, no error.
  - The grant is held after an error; the initiator decides whether to drop cyc.
- Simultaneous requests: the rotating priority guarantees no initiator waits more than NM-1 grants.
- Grant hand-off: an initiator that deasserts cyc while a slave ack is in flight loses the ack. Slaves must not ack after stb falls.
- Reset mid-cycle drops the grant immediately; the downstream sees s_cyc_o/s_stb_o fall asynchronously.
- TIMEOUT=0: wdt is constant 0 and m_err_o is tied to 0.

Decomposition:
- Shared package (wb_pkg): AW, DW, SW constants and clog2 helper. The decoder uses the same constants.
- One sub-module, `rr_pick`: combinational round-robin priority picker (inputs req[NM], last; outputs one-hot pick and index). It is reused by any future interrupt arbiter.

Test Plan:
- Single initiator:
  - Stimulus: after reset, m_cyc_i=01, m_stb_i=01, adr0=0x1000_0004, slave acks 2 cycles after s_stb_o.
  - Expected: s_cyc_o rises 1 cycle after the request, s_adr_o=0x1000_0004, m_ack_o=01 for 1 cycle, m_ack_o[1] stays 0.
- Contention / round robin:
  - Stimulus: m_cyc_i=11 continuously, each initiator drops cyc for 1 cycle after its ack.
  - Expected: grants alternate 0,1,0,1 with one idle cycle between them. last=NM-1 at reset, so initiator 0 wins first.
- Bus lock:
  - Stimulus: initiator 1 holds cyc across 4 stb beats while initiator 0 requests.
  - Expected: initiator 0 is granted only after cyc1 falls, and all 4 acks go to initiator 1.
- Watchdog:
  - Stimulus: TIMEOUT=8, slave never acks.
  - Expected: m_err_o[g] pulses on the 9th cycle of stb, s_stb_o is 0 in that cycle, wdt returns to 0. Repeated stb produces a second error 9 cycles later.
- Ack at the limit:
  - Stimulus: TIMEOUT=8, ack arrives exactly in the cycle wdt==8.
  - Expected: m_ack_o pulses and m_err_o stays 0.
- Reset mid-cycle:
  - Stimulus: assert rst_i while granted and stb is high.
  - Expected: s_cyc_o, s_stb_o and m_ack_o go to 0 without a clock edge. After release, the first grant goes to initiator 0.
